cascade_slave_responder: RTL and testbench
==========================================

// Module: cascade_slave_responder
// PURPOSE
//  Slave-side end of the 8259 cascade protocol: in a slave PIC, tracks the two-pulse
//  8086-mode INTA sequence and samples the master-driven CAS[2:0] lines. When the
//  cascade code equals this slave's ID and an interrupt is pending, it sets ISR and
//  drives the vector {ICW2[7:3], level} on the second pulse. Sits between bus/INTA
//  logic and priority resolver/ISR; inactive whenever the device is master (sp_en=1).
// PARAMETERS
//  SYNC_STAGES  2    flops in the inta_n synchroniser (>=2)
//  TIMEOUT      64   clk cycles allowed between INTA pulses before abort (>=2)
// PORTS
//  clk            in   1  system clock, all logic rising-edge
//  rst_n          in   1  asynchronous active-low reset
//  inta_n         in   1  CPU interrupt-acknowledge strobe, async, active-low
//  cas_in         in   3  cascade lines as received from master
//  sp_en          in   1  1=master (block held idle), 0=slave
//  slave_id       in   3  ICW3[2:0] of this slave
//  int_pending    in   1  resolver has an unmasked request
//  irq_level      in   3  highest-priority pending level
//  vector_base    in   5  ICW2[7:3]
//  aeoi           in   1  ICW4 auto-EOI enable
//  data_out       out  8  vector byte
//  data_oe        out  1  drive enable for data_out onto D[7:0]
//  selected       out  1  this slave addressed in current sequence
//  isr_set        out  1  one-cycle strobe: set ISR bit isr_level
//  isr_clr        out  1  one-cycle strobe: clear ISR bit isr_level (AEOI)
//  isr_level      out  3  level latched for current sequence
//  timeout_err    out  1  one-cycle strobe: sequence aborted by timeout
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, timeout counter 0; same values on reset mid-sequence.
//  - inta_n passes SYNC_STAGES flops, then edge detector gives fall/rise pulses.
//  - FSM: IDLE -fall-> ACK1 -rise-> GAP -fall-> ACK2 -rise-> IDLE.
//  - IDLE->ACK1: latch irq_level into isr_level, pend_q<=int_pending.
//  - ACK1->GAP (rise): sample cas_in; selected<=(cas_in==slave_id)&pend_q;
//    if selected, isr_set=1 for exactly that cycle.
//  - GAP->ACK2 (fall): if selected, data_oe<=1, data_out<={vector_base,isr_level}
//    on same edge (SYNC_STAGES+1 clks after inta_n pin falls). Else no drive.
//  - ACK2->IDLE (rise): data_oe<=0, data_out<=0; if selected&aeoi, isr_clr=1 one
//    cycle; selected<=0 same edge.
//  - data_out/data_oe constant through ACK2; vector_base/irq_level changes ignored.
//  - Timeout: counter runs only in GAP, clears on leaving it; reaching TIMEOUT ->
//    IDLE, timeout_err=1 one cycle, selected<=0, no ISR clear.
//  - sp_en=1 (any state): next edge forces IDLE, data_oe=0, selected=0, no strobes.
//  - fall and rise can't coincide (one detector output); glitch shorter than
//    synchroniser unsupported. isr_set and isr_clr never in same cycle.
//  - cas_in compared only at the ACK1 rise sample; other times ignored.
// STRUCTURE
//  - pic_pkg: FSM state enum (IDLE,ACK1,GAP,ACK2), CAS_W=3, LEVEL_W=3,
//    vector-compose function.
//  - Sub-module inta_edge_sync: SYNC_STAGES synchroniser + fall/rise pulse outputs.
//  - Timeout counter width $clog2(TIMEOUT+1), in top level.
// TESTING
//  1 id=3, pend, lvl=5, base=5'h11, cas=3 -> isr_set 1 clk after 1st rise;
//    data_out=8'h8D, data_oe high for all of 2nd pulse; no isr_clr.
//  2 as 1, aeoi=1 -> isr_clr one cycle at 2nd rise, isr_level=5.
//  3 cas=2, id=3 -> selected=0, no isr_set, data_oe stays 0; FSM back to IDLE.
//  4 no 2nd pulse, TIMEOUT=8 -> timeout_err after 8 GAP cycles, IDLE; late pulse
//    starts new sequence.
//  5 rst_n low in ACK2 while data_oe=1 -> data_oe=0 async; no strobes after release.
//  6 sp_en=1 full INTA sequence, cas matching -> all outputs stay 0.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259 slave cascade responder.
// Holds the cascade FSM encoding, field widths and the INTA vector composition.
package pic_pkg;

    localparam int CAS_W   = 3;
    localparam int LEVEL_W = 3;
    localparam int BASE_W  = 5;
    localparam int VEC_W   = BASE_W + LEVEL_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_GAP  = 2'd2,
        ST_ACK2 = 2'd3
    } cas_state_e;

    // 8086-mode vector: ICW2[7:3] supplies the upper bits, the level the lower three
    function automatic logic [VEC_W-1:0] compose_vector(
        input logic [BASE_W-1:0]  base,
        input logic [LEVEL_W-1:0] level
    );
        return {base, level};
    endfunction

endpackage

// File: rtl/inta_edge_sync.sv
// Synchronises the asynchronous INTA strobe and produces single-cycle
// fall/rise pulses from the synchronised level.
module inta_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain plus one history flop for edge detection; idles high (no ack)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], inta_n};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Only fully synchronised bits feed the detector, so fall and rise are exclusive
    assign fall = prev_r & ~sync_r[SYNC_STAGES-1];
    assign rise = ~prev_r & sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/cascade_slave_responder.sv
// Slave-side 8259 cascade responder: follows the two-pulse INTA sequence, matches
// the master's CAS code against this slave's ID and supplies the vector byte.
module cascade_slave_responder
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inta_n,
    input  logic [CAS_W-1:0]   cas_in,
    input  logic               sp_en,
    input  logic [CAS_W-1:0]   slave_id,
    input  logic               int_pending,
    input  logic [LEVEL_W-1:0] irq_level,
    input  logic [BASE_W-1:0]  vector_base,
    input  logic               aeoi,
    output logic [VEC_W-1:0]   data_out,
    output logic               data_oe,
    output logic               selected,
    output logic               isr_set,
    output logic               isr_clr,
    output logic [LEVEL_W-1:0] isr_level,
    output logic               timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic               fall_s;
    logic               rise_s;
    logic               cas_hit_s;

    cas_state_e         state_r;
    logic               pend_r;
    logic               selected_r;
    logic               data_oe_r;
    logic [VEC_W-1:0]   data_out_r;
    logic               isr_set_r;
    logic               isr_clr_r;
    logic [LEVEL_W-1:0] isr_level_r;
    logic               timeout_err_r;
    logic [TMO_W-1:0]   tmo_cnt_r;

    inta_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_inta_edge_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .inta_n (inta_n),
        .fall   (fall_s),
        .rise   (rise_s)
    );

    assign cas_hit_s = (cas_in == slave_id) && pend_r;

    // Cascade sequence FSM with registered outputs; strobes default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pend_r        <= 1'b0;
            selected_r    <= 1'b0;
            data_oe_r     <= 1'b0;
            data_out_r    <= {VEC_W{1'b0}};
            isr_set_r     <= 1'b0;
            isr_clr_r     <= 1'b0;
            isr_level_r   <= {LEVEL_W{1'b0}};
            timeout_err_r <= 1'b0;
            tmo_cnt_r     <= {TMO_W{1'b0}};
        end else begin
            isr_set_r     <= 1'b0;
            isr_clr_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            if (sp_en) begin
                // A master never answers as a slave, whatever state it was in
                state_r    <= ST_IDLE;
                selected_r <= 1'b0;
                data_oe_r  <= 1'b0;
                data_out_r <= {VEC_W{1'b0}};
                tmo_cnt_r  <= {TMO_W{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (fall_s) begin
                            state_r     <= ST_ACK1;
                            isr_level_r <= irq_level;
                            pend_r      <= int_pending;
                        end
                    end
                    ST_ACK1: begin
                        if (rise_s) begin
                            state_r    <= ST_GAP;
                            tmo_cnt_r  <= {TMO_W{1'b0}};
                            selected_r <= cas_hit_s;
                            isr_set_r  <= cas_hit_s;
                        end
                    end
                    ST_GAP: begin
                        if (fall_s) begin
                            state_r   <= ST_ACK2;
                            tmo_cnt_r <= {TMO_W{1'b0}};
                            if (selected_r) begin
                                data_oe_r  <= 1'b1;
                                data_out_r <= compose_vector(vector_base, isr_level_r);
                            end
                        end else if (tmo_cnt_r == TMO_LAST) begin
                            // Second pulse never came: abandon without touching ISR
                            state_r       <= ST_IDLE;
                            tmo_cnt_r     <= {TMO_W{1'b0}};
                            selected_r    <= 1'b0;
                            timeout_err_r <= 1'b1;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_ACK2: begin
                        if (rise_s) begin
                            state_r    <= ST_IDLE;
                            data_oe_r  <= 1'b0;
                            data_out_r <= {VEC_W{1'b0}};
                            isr_clr_r  <= selected_r & aeoi;
                            selected_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        selected_r <= 1'b0;
                        data_oe_r  <= 1'b0;
                        data_out_r <= {VEC_W{1'b0}};
                        tmo_cnt_r  <= {TMO_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign data_out    = data_out_r;
    assign data_oe     = data_oe_r;
    assign selected    = selected_r;
    assign isr_set     = isr_set_r;
    assign isr_clr     = isr_clr_r;
    assign isr_level   = isr_level_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_cascade_slave_responder.sv
// Self-checking bench for cascade_slave_responder: directed cases then random
// INTA sequences checked cycle-by-cycle against expectations from the protocol rules.
module tb_cascade_slave_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inta_n = 1'b1;
    logic [2:0] cas_in = 3'd0;
    logic       sp_en = 1'b0;
    logic [2:0] slave_id = 3'd0;
    logic       int_pending = 1'b0;
    logic [2:0] irq_level = 3'd0;
    logic [4:0] vector_base = 5'd0;
    logic       aeoi = 1'b0;
    logic [7:0] data_out;
    logic       data_oe;
    logic       selected;
    logic       isr_set;
    logic       isr_clr;
    logic [2:0] isr_level;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail = 0;
    int n_set = 0;
    int n_clr = 0;
    int n_tmo = 0;
    logic overlap_seen = 1'b0;
    logic [2:0] model_lvl = 3'd0;

    cascade_slave_responder #(
        .SYNC_STAGES (2),
        .TIMEOUT     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inta_n      (inta_n),
        .cas_in      (cas_in),
        .sp_en       (sp_en),
        .slave_id    (slave_id),
        .int_pending (int_pending),
        .irq_level   (irq_level),
        .vector_base (vector_base),
        .aeoi        (aeoi),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .selected    (selected),
        .isr_set     (isr_set),
        .isr_clr     (isr_clr),
        .isr_level   (isr_level),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Strobe monitor sampled on the inactive edge
    always @(negedge clk) begin
        if (isr_set) n_set <= n_set + 1;
        if (isr_clr) n_clr <= n_clr + 1;
        if (timeout_err) n_tmo <= n_tmo + 1;
        if (isr_set && isr_clr) overlap_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One two-pulse INTA sequence; expectations derived from the inputs at its start
    task automatic run_seq(input int l1, input int h, input int l2, input bit churn);
        logic       exp_sel;
        logic       exp_clr;
        logic [7:0] exp_vec;
        logic       on;
        exp_sel = !sp_en && int_pending && (cas_in == slave_id);
        exp_clr = exp_sel && aeoi;
        exp_vec = 8'(int'(vector_base) * 8 + int'(irq_level));
        if (!sp_en) model_lvl = irq_level;
        inta_n = 1'b0;
        repeat (l1) @(negedge clk);
        inta_n = 1'b1;
        for (int k = 1; k <= h; k++) begin
            @(negedge clk);
            chk("isr_set_gap", 8'(isr_set), 8'(exp_sel && k == 3));
            chk("tmo_gap", 8'(timeout_err), 8'd0);
            if (churn && k == 3) begin
                cas_in = 3'($urandom_range(0, 7));
                int_pending = 1'($urandom_range(0, 1));
            end
            if (k == h) chk("selected_gap", 8'(selected), 8'(exp_sel));
        end
        inta_n = 1'b0;
        for (int k = 1; k <= l2; k++) begin
            @(negedge clk);
            on = exp_sel && k >= 3;
            chk("oe_ack2", 8'(data_oe), 8'(on));
            chk("vec_ack2", data_out, on ? exp_vec : 8'd0);
            if (churn && k == 3) begin
                vector_base = 5'($urandom_range(0, 31));
                irq_level = 3'($urandom_range(0, 7));
                cas_in = 3'($urandom_range(0, 7));
            end
        end
        inta_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            on = exp_sel && k <= 2;
            chk("oe_tail", 8'(data_oe), 8'(on));
            chk("vec_tail", data_out, on ? exp_vec : 8'd0);
            chk("isr_clr_tail", 8'(isr_clr), 8'(exp_clr && k == 3));
            chk("selected_tail", 8'(selected), 8'(on));
        end
        chk("isr_level", 8'(isr_level), 8'(model_lvl));
    endtask

    initial begin
        int set0;
        int clr0;
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 8'd0);
        chk("rst_data_oe", 8'(data_oe), 8'd0);
        chk("rst_selected", 8'(selected), 8'd0);
        chk("rst_isr_set", 8'(isr_set), 8'd0);
        chk("rst_isr_clr", 8'(isr_clr), 8'd0);
        chk("rst_isr_level", 8'(isr_level), 8'd0);
        chk("rst_tmo", 8'(timeout_err), 8'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: matched slave, no AEOI -> vector 8'h8D
        slave_id = 3'd3; cas_in = 3'd3; int_pending = 1'b1;
        irq_level = 3'd5; vector_base = 5'h11; aeoi = 1'b0;
        run_seq(5, 4, 6, 1'b0);
        // 2: same with AEOI
        cas_in = 3'd3; int_pending = 1'b1; irq_level = 3'd5; vector_base = 5'h11; aeoi = 1'b1;
        run_seq(5, 4, 6, 1'b0);
        chk("t2_isr_level", 8'(isr_level), 8'd5);
        // 3: cascade code addresses another slave
        cas_in = 3'd2; aeoi = 1'b0;
        run_seq(5, 4, 6, 1'b0);

        // 4: second pulse never arrives
        cas_in = 3'd3; int_pending = 1'b1; irq_level = 3'd2;
        inta_n = 1'b0;
        repeat (5) @(negedge clk);
        inta_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk("t4_tmo", 8'(timeout_err), 8'(k == 11));
            chk("t4_isr_set", 8'(isr_set), 8'(k == 3));
            chk("t4_isr_clr", 8'(isr_clr), 8'd0);
            if (k == 10) chk("t4_sel_before", 8'(selected), 8'd1);
            if (k == 12) chk("t4_sel_after", 8'(selected), 8'd0);
        end
        chk("t4_tmo_count", 8'(n_tmo), 8'd1);
        cas_in = 3'd3; irq_level = 3'd6; vector_base = 5'h0A; aeoi = 1'b1;
        run_seq(4, 3, 5, 1'b0);

        // 5: reset during the second pulse while driving
        cas_in = 3'd3; int_pending = 1'b1; aeoi = 1'b1;
        inta_n = 1'b0;
        repeat (5) @(negedge clk);
        inta_n = 1'b1;
        repeat (4) @(negedge clk);
        inta_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_oe_before", 8'(data_oe), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_oe_async", 8'(data_oe), 8'd0);
        chk("t5_sel_async", 8'(selected), 8'd0);
        chk("t5_vec_async", data_out, 8'd0);
        @(negedge clk);
        inta_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set0 = n_set;
        clr0 = n_clr;
        repeat (10) @(negedge clk);
        chk("t5_no_set", 8'(n_set - set0), 8'd0);
        chk("t5_no_clr", 8'(n_clr - clr0), 8'd0);
        chk("t5_oe_idle", 8'(data_oe), 8'd0);
        model_lvl = 3'd0;

        // 6: master mode ignores a matching sequence
        sp_en = 1'b1; cas_in = 3'd3; slave_id = 3'd3; int_pending = 1'b1; aeoi = 1'b1;
        run_seq(5, 4, 6, 1'b0);
        sp_en = 1'b0;
        repeat (2) @(negedge clk);

        // Random sequences
        for (int i = 0; i < 24; i++) begin
            slave_id = 3'($urandom_range(0, 7));
            cas_in = ($urandom_range(0, 1) == 1) ? slave_id : 3'($urandom_range(0, 7));
            int_pending = 1'($urandom_range(0, 3) != 0);
            irq_level = 3'($urandom_range(0, 7));
            vector_base = 5'($urandom_range(0, 31));
            aeoi = 1'($urandom_range(0, 1));
            sp_en = 1'($urandom_range(0, 7) == 0);
            run_seq(int'($urandom_range(3, 7)), int'($urandom_range(3, 6)),
                    int'($urandom_range(3, 7)), 1'b1);
            sp_en = 1'b0;
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
        end

        chk("no_set_clr_overlap", 8'(overlap_seen), 8'd0);
        chk("tmo_total", 8'(n_tmo), 8'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
